// File: rtl/rp_pkg.sv
// Shared types for the load writeback unit: funct3 load codes,
// FSM states and the load byte/halfword extract function.
package rp_pkg;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic        ok;
    logic [31:0] dat;
  } ext_t;

  // ok=0 flags a misaligned offset or a reserved funct3
  function automatic ext_t ld_ext(
    input logic [2:0]  fn,
    input logic [1:0]  off,
    input logic [31:0] w
  );
    ext_t        r;
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    r = '{ok: 1'b0, dat: 32'd0};
    case (fn)
      F_LB: begin
        r.ok  = 1'b1;
        r.dat = {{24{b[7]}}, b};
      end
      F_LH: begin
        r.ok  = ~off[0];
        r.dat = {{16{h[15]}}, h};
      end
      F_LW: begin
        r.ok  = (off == 2'd0);
        r.dat = w;
      end
      F_LBU: begin
        r.ok  = 1'b1;
        r.dat = {24'd0, b};
      end
      F_LHU: begin
        r.ok  = ~off[0];
        r.dat = {16'd0, h};
      end
      default: r = '{ok: 1'b0, dat: 32'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rp_wbu_if.sv
// Load issue and memory response handshake bundle.
// master drives requests/responses, slave is the writeback unit.
interface rp_wbu_if #(
  parameter int AW = 5,
  parameter int XW = 32
);
  logic          ld_vld;
  logic          ld_rdy;
  logic [AW-1:0] ld_rd;
  logic [2:0]    ld_fn;
  logic [1:0]    ld_off;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [XW-1:0] rsp_dat;

  modport master (
    output ld_vld, ld_rd, ld_fn, ld_off,
    output rsp_vld, rsp_dat,
    input  ld_rdy, rsp_rdy
  );

  modport slave (
    input  ld_vld, ld_rd, ld_fn, ld_off,
    input  rsp_vld, rsp_dat,
    output ld_rdy, rsp_rdy
  );
endinterface

// File: rtl/rp_wbu_ext.sv
// Combinational load extract / sign-extend of a raw aligned word.
module rp_wbu_ext
  import rp_pkg::*;
(
  input  logic [2:0]  i_fn,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_dat,
  output logic        o_ok,
  output logic [31:0] o_dat
);
  ext_t w_r;

  assign w_r   = ld_ext(i_fn, i_off, i_dat);
  assign o_ok  = w_r.ok;
  assign o_dat = w_r.dat;
endmodule

// File: rtl/rp_wbu.sv
// Load writeback unit: arbitrates ALU and load results onto one GPR
// write port. Optional forwarding enabled by macro RP_WBU_FWD_EN.
module rp_wbu
  import rp_pkg::*;
#(
  parameter int AW = 5,
  parameter int XW = 32
) (
  input  logic          clk,
  input  logic          rst,
  rp_wbu_if.slave       lsu,
  input  logic          alu_vld,
  input  logic [AW-1:0] alu_rd,
  input  logic [XW-1:0] alu_dat,
  input  logic          e_rs1,
  input  logic [AW-1:0] a_rs1,
  input  logic          e_rs2,
  input  logic [AW-1:0] a_rs2,
  input  logic          e_rdq,
  input  logic [AW-1:0] a_rdq,
  output logic          hazard,
  output logic          e_rd,
  output logic [AW-1:0] a_rd,
  output logic [XW-1:0] d_rd,
  output logic          busy,
`ifdef RP_WBU_FWD_EN
  output logic          fwd_rs1,
  output logic          fwd_rs2,
  output logic [XW-1:0] fwd_d,
`endif
  output logic          err
);

  if (XW != 32) begin : g_xw_chk
    $error("rp_wbu: only XW=32 is supported");
  end

  state_t        r_st;
  state_t        w_nx;
  logic [AW-1:0] r_rd;
  logic [2:0]    r_fn;
  logic [1:0]    r_off;
  logic [XW-1:0] r_buf;
  logic          w_iss;
  logic          w_acc;
  logic          w_ok;
  logic [XW-1:0] w_x;
  logic          w_hit;
  logic          w_lwr;
  logic          w_cap;

  rp_wbu_ext u_ext (
    .i_fn  (r_fn),
    .i_off (r_off),
    .i_dat (lsu.rsp_dat),
    .o_ok  (w_ok),
    .o_dat (w_x)
  );

  assign lsu.ld_rdy  = (r_st == S_IDLE);
  assign lsu.rsp_rdy = (r_st != S_HOLD);
  assign w_iss = lsu.ld_vld & lsu.ld_rdy;
  assign w_acc = lsu.rsp_vld & lsu.rsp_rdy;
  assign busy  = (r_st != S_IDLE);
  assign w_cap = (r_st == S_WAIT) & w_acc & w_ok & alu_vld;

  // load result reaches the port this cycle
  assign w_lwr = ~alu_vld & ((r_st == S_HOLD) |
    ((r_st == S_WAIT) & w_acc & w_ok));

  always_comb begin
    w_nx = r_st;
    err  = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        err = w_acc;
        if (w_iss) w_nx = S_WAIT;
      end
      S_WAIT: begin
        if (w_acc) begin
          err  = ~w_ok;
          w_nx = w_cap ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (!alu_vld) w_nx = S_IDLE;
      end
      default: w_nx = S_IDLE;
    endcase
    if (rst) err = 1'b0;
  end

  always_comb begin
    e_rd = 1'b0;
    a_rd = '0;
    d_rd = '0;
    unique case (1'b1)
      alu_vld: begin
        e_rd = 1'b1;
        a_rd = alu_rd;
        d_rd = alu_dat;
      end
      w_lwr: begin
        e_rd = 1'b1;
        a_rd = r_rd;
        d_rd = (r_st == S_HOLD) ? r_buf : w_x;
      end
      default: ;
    endcase
  end

  assign w_hit = (e_rs1 & (a_rs1 == r_rd)) |
                 (e_rs2 & (a_rs2 == r_rd)) |
                 (e_rdq & (a_rdq == r_rd));

`ifdef RP_WBU_FWD_EN
  assign hazard  = busy & (r_rd != '0) & w_hit & ~w_lwr;
  assign fwd_rs1 = w_lwr & e_rs1 & (a_rs1 == r_rd) & (r_rd != '0);
  assign fwd_rs2 = w_lwr & e_rs2 & (a_rs2 == r_rd) & (r_rd != '0);
  assign fwd_d   = d_rd;
`else
  assign hazard  = busy & (r_rd != '0) & w_hit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st  <= S_IDLE;
      r_rd  <= '0;
      r_fn  <= '0;
      r_off <= '0;
      r_buf <= '0;
    end else begin
      r_st <= w_nx;
      if (w_iss) begin
        r_rd  <= lsu.ld_rd;
        r_fn  <= lsu.ld_fn;
        r_off <= lsu.ld_off;
      end
      if (w_cap) r_buf <= w_x;
    end
  end

endmodule

// File: tb/tb_rp_wbu.sv
// Directed self-checking bench for rp_wbu.
// Inputs change 1ns after posedge; outputs sampled at negedge.
module tb_rp_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_vld;
  logic [4:0]  alu_rd;
  logic [31:0] alu_dat;
  logic        e_rs1, e_rs2, e_rdq;
  logic [4:0]  a_rs1, a_rs2, a_rdq;
  logic        hazard, e_rd, busy, err;
  logic [4:0]  a_rd;
  logic [31:0] d_rd;
`ifdef RP_WBU_FWD_EN
  logic        fwd_rs1, fwd_rs2;
  logic [31:0] fwd_d;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  rp_wbu_if #(.AW(5), .XW(32)) lsu ();

  rp_wbu #(.AW(5), .XW(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .lsu     (lsu),
    .alu_vld (alu_vld),
    .alu_rd  (alu_rd),
    .alu_dat (alu_dat),
    .e_rs1   (e_rs1),
    .a_rs1   (a_rs1),
    .e_rs2   (e_rs2),
    .a_rs2   (a_rs2),
    .e_rdq   (e_rdq),
    .a_rdq   (a_rdq),
    .hazard  (hazard),
    .e_rd    (e_rd),
    .a_rd    (a_rd),
    .d_rd    (d_rd),
    .busy    (busy),
`ifdef RP_WBU_FWD_EN
    .fwd_rs1 (fwd_rs1),
    .fwd_rs2 (fwd_rs2),
    .fwd_d   (fwd_d),
`endif
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rd,
                       input logic [2:0] fn,
                       input logic [1:0] off);
    lsu.ld_vld = 1'b1;
    lsu.ld_rd  = rd;
    lsu.ld_fn  = fn;
    lsu.ld_off = off;
    mid();
    chk("ld_rdy", {31'd0, lsu.ld_rdy}, 32'd1);
    tick();
    lsu.ld_vld = 1'b0;
  endtask

  task automatic load(input string tag,
                      input logic [4:0]  rd,
                      input logic [2:0]  fn,
                      input logic [1:0]  off,
                      input logic [31:0] dat,
                      input logic [31:0] exp);
    issue(rd, fn, off);
    lsu.rsp_vld = 1'b1;
    lsu.rsp_dat = dat;
    mid();
    chk({tag, ".e_rd"}, {31'd0, e_rd}, 32'd1);
    chk({tag, ".a_rd"}, {27'd0, a_rd}, {27'd0, rd});
    chk({tag, ".d_rd"}, d_rd, exp);
    tick();
    lsu.rsp_vld = 1'b0;
    mid();
    chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    alu_vld = 1'b1; alu_rd = 5'd2; alu_dat = 32'h1234;
    e_rs1 = 0; e_rs2 = 0; e_rdq = 0;
    a_rs1 = 0; a_rs2 = 0; a_rdq = 0;
    lsu.ld_vld = 0; lsu.ld_rd = 0; lsu.ld_fn = 0; lsu.ld_off = 0;
    lsu.rsp_vld = 0; lsu.rsp_dat = 0;
    mid();
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.err", {31'd0, err}, 32'd0);
    chk("rst.e_rd_alu", {31'd0, e_rd}, 32'd1);
    chk("rst.rsp_rdy", {31'd0, lsu.rsp_rdy}, 32'd1);
    tick();
    alu_vld = 1'b0;
    mid();
    chk("rst.e_rd_off", {31'd0, e_rd}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    load("lw",  5'd3,  LW,  2'd0, 32'h8000_00FF, 32'h8000_00FF);
    load("lb",  5'd4,  LB,  2'd3, 32'h8012_3456, 32'hFFFF_FF80);
    load("lbu", 5'd4,  LBU, 2'd3, 32'h8012_3456, 32'h0000_0080);
    load("lhu", 5'd8,  LHU, 2'd2, 32'hBEEF_1234, 32'h0000_BEEF);
    load("lh",  5'd10, LH,  2'd0, 32'h1234_8001, 32'hFFFF_8001);
    load("lb1", 5'd11, LB,  2'd1, 32'h0000_7F00, 32'h0000_007F);
    load("x0",  5'd0,  LW,  2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // response collides with three ALU writes
    issue(5'd7, LW, 2'd0);
    lsu.rsp_vld = 1'b1; lsu.rsp_dat = 32'hCAFE_F00D;
    alu_vld = 1'b1; alu_rd = 5'd9; alu_dat = 32'h111;
    mid();
    chk("hold.c1.a_rd", {27'd0, a_rd}, 32'd9);
    chk("hold.c1.d_rd", d_rd, 32'h111);
    tick();
    lsu.rsp_vld = 1'b0; alu_dat = 32'h222;
    mid();
    chk("hold.c2.rsp_rdy", {31'd0, lsu.rsp_rdy}, 32'd0);
    chk("hold.c2.d_rd", d_rd, 32'h222);
    tick();
    alu_dat = 32'h333;
    mid();
    chk("hold.c3.rsp_rdy", {31'd0, lsu.rsp_rdy}, 32'd0);
    chk("hold.c3.d_rd", d_rd, 32'h333);
    tick();
    alu_vld = 1'b0;
    mid();
    chk("hold.c4.e_rd", {31'd0, e_rd}, 32'd1);
    chk("hold.c4.a_rd", {27'd0, a_rd}, 32'd7);
    chk("hold.c4.d_rd", d_rd, 32'hCAFE_F00D);
    chk("hold.c4.rsp_rdy", {31'd0, lsu.rsp_rdy}, 32'd0);
    tick();
    mid();
    chk("hold.end.busy", {31'd0, busy}, 32'd0);
    chk("hold.end.e_rd", {31'd0, e_rd}, 32'd0);
    tick();

    // hazard against pending rd=5
    issue(5'd5, LW, 2'd0);
    e_rs2 = 1'b1; a_rs2 = 5'd5;
    mid();
    chk("hz.rs2", {31'd0, hazard}, 32'd1);
    a_rs2 = 5'd0;
    #1;
    chk("hz.rs2_x0", {31'd0, hazard}, 32'd0);
    e_rs2 = 1'b0; a_rs2 = 5'd5;
    #1;
    chk("hz.rs2_off", {31'd0, hazard}, 32'd0);
    e_rdq = 1'b1; a_rdq = 5'd5;
    #1;
    chk("hz.rdq", {31'd0, hazard}, 32'd1);
    e_rdq = 1'b0;
    tick();
    e_rs1 = 1'b1; a_rs1 = 5'd5;
    lsu.rsp_vld = 1'b1; lsu.rsp_dat = 32'h0BAD_F00D;
    mid();
    chk("hz.cmp.d_rd", d_rd, 32'h0BAD_F00D);
`ifdef RP_WBU_FWD_EN
    chk("fwd.hazard", {31'd0, hazard}, 32'd0);
    chk("fwd.rs1", {31'd0, fwd_rs1}, 32'd1);
    chk("fwd.rs2", {31'd0, fwd_rs2}, 32'd0);
    chk("fwd.d", fwd_d, 32'h0BAD_F00D);
`else
    chk("hz.cmp", {31'd0, hazard}, 32'd1);
`endif
    tick();
    lsu.rsp_vld = 1'b0;
    mid();
    chk("hz.idle", {31'd0, hazard}, 32'd0);
    tick();
    e_rs1 = 1'b0;

    // pending x0 never hazards
    issue(5'd0, LW, 2'd0);
    e_rs1 = 1'b1; a_rs1 = 5'd0;
    mid();
    chk("hz.x0", {31'd0, hazard}, 32'd0);
    chk("hz.x0.busy", {31'd0, busy}, 32'd1);
    tick();
    e_rs1 = 1'b0;
    lsu.rsp_vld = 1'b1; lsu.rsp_dat = 32'h1;
    tick();
    lsu.rsp_vld = 1'b0;

    // misaligned LH and reserved funct3
    issue(5'd12, LH, 2'd1);
    lsu.rsp_vld = 1'b1; lsu.rsp_dat = 32'hFFFF_FFFF;
    mid();
    chk("mis.err", {31'd0, err}, 32'd1);
    chk("mis.e_rd", {31'd0, e_rd}, 32'd0);
    tick();
    lsu.rsp_vld = 1'b0;
    mid();
    chk("mis.err_clr", {31'd0, err}, 32'd0);
    chk("mis.busy", {31'd0, busy}, 32'd0);
    tick();
    issue(5'd13, 3'b011, 2'd0);
    lsu.rsp_vld = 1'b1;
    mid();
    chk("rsv.err", {31'd0, err}, 32'd1);
    chk("rsv.e_rd", {31'd0, e_rd}, 32'd0);
    tick();
    lsu.rsp_vld = 1'b0;
    tick();

    // spurious response in IDLE
    lsu.rsp_vld = 1'b1; lsu.rsp_dat = 32'h5555_5555;
    mid();
    chk("spur.err", {31'd0, err}, 32'd1);
    chk("spur.e_rd", {31'd0, e_rd}, 32'd0);
    tick();
    lsu.rsp_vld = 1'b0;
    tick();

    // reset while a load is outstanding
    issue(5'd6, LW, 2'd0);
    rst = 1'b1;
    #1;
    chk("rw.busy", {31'd0, busy}, 32'd0);
    chk("rw.err", {31'd0, err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    lsu.rsp_vld = 1'b1; lsu.rsp_dat = 32'h7777_7777;
    mid();
    chk("rw.late.err", {31'd0, err}, 32'd1);
    chk("rw.late.e_rd", {31'd0, e_rd}, 32'd0);
    chk("rw.late.busy", {31'd0, busy}, 32'd0);
    tick();
    lsu.rsp_vld = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
